// File: rtl/gpr_pkg.sv
// Shared defaults for the general-purpose register bank and its busy scoreboard.
package gpr_pkg;

    localparam int GPR_DATA_W   = 32;
    localparam int GPR_NREG     = 32;
    localparam int GPR_NRD      = 2;
    localparam int GPR_ZERO_REG = 0;

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register busy bits: set on issue, cleared by an effective writeback.
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int NREG = GPR_NREG,
    localparam int ADDR_W = $clog2(NREG)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              IssueEn,
    input  logic [ADDR_W-1:0] IssueReg,
    input  logic              WrEnA,
    input  logic [ADDR_W-1:0] WrRegA,
    input  logic              WrEnB,
    input  logic [ADDR_W-1:0] WrRegB,
    output logic [NREG-1:0]   Busy,
    output logic              AnyBusy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Set is applied after the clears so a newer producer wins over a same-cycle writeback.
    always_comb begin
        busy_d = busy_q;
        if (WrEnA) busy_d[WrRegA] = 1'b0;
        if (WrEnB) busy_d[WrRegB] = 1'b0;
        if (IssueEn && (IssueReg != ADDR_W'(GPR_ZERO_REG))) busy_d[IssueReg] = 1'b1;
        busy_d[GPR_ZERO_REG] = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign Busy    = busy_q;
    assign AnyBusy = |busy_q;

endmodule

// File: rtl/gpr_bank.sv
// Dual-write, multi-read register bank with write-first bypass and a busy scoreboard.
module gpr_bank
    import gpr_pkg::*;
#(
    parameter int DATA_W = GPR_DATA_W,
    parameter int NREG   = GPR_NREG,
    parameter int NRD    = GPR_NRD,
    localparam int ADDR_W = $clog2(NREG)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [NRD*ADDR_W-1:0] Rreg,
    output logic [NRD*DATA_W-1:0] Rdata,
    output logic [NRD-1:0]        RBusy,
    input  logic                  WEa,
    input  logic [ADDR_W-1:0]     Wrega,
    input  logic [DATA_W-1:0]     Wdataa,
    input  logic                  WEb,
    input  logic [ADDR_W-1:0]     Wregb,
    input  logic [DATA_W-1:0]     Wdatab,
    input  logic                  IssueEn,
    input  logic [ADDR_W-1:0]     IssueReg,
    output logic                  AnyBusy
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   busy;
    logic              wa_eff;
    logic              wb_eff;

    // Gating with Reset also disables bypass while reset is held.
    assign wa_eff = WEa && (Wrega != ADDR_W'(GPR_ZERO_REG)) && !Reset;
    assign wb_eff = WEb && (Wregb != ADDR_W'(GPR_ZERO_REG)) && !Reset
                    && !(wa_eff && (Wregb == Wrega));

    always_comb begin
        regs_d = regs_q;
        if (wa_eff) regs_d[Wrega] = Wdataa;
        if (wb_eff) regs_d[Wregb] = Wdatab;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    gpr_scoreboard #(.NREG(NREG)) u_scoreboard (
        .Clk      (Clk),
        .Reset    (Reset),
        .IssueEn  (IssueEn && !Reset),
        .IssueReg (IssueReg),
        .WrEnA    (wa_eff),
        .WrRegA   (Wrega),
        .WrEnB    (wb_eff),
        .WrRegB   (Wregb),
        .Busy     (busy),
        .AnyBusy  (AnyBusy)
    );

    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic              hit_a;
        logic              hit_b;
        Rdata = '0;
        RBusy = '0;
        ra    = '0;
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            ra    = Rreg[i*ADDR_W +: ADDR_W];
            hit_a = wa_eff && (Wrega == ra);
            hit_b = wb_eff && (Wregb == ra);
            if (ra == ADDR_W'(GPR_ZERO_REG)) Rdata[i*DATA_W +: DATA_W] = '0;
            else if (hit_a)                  Rdata[i*DATA_W +: DATA_W] = Wdataa;
            else if (hit_b)                  Rdata[i*DATA_W +: DATA_W] = Wdatab;
            else                             Rdata[i*DATA_W +: DATA_W] = regs_q[ra];
            RBusy[i] = busy[ra] && !hit_a && !hit_b && !Reset;
        end
    end

endmodule

// File: doc/gpr_bank.md
GPR_BANK -- requirements
Module: gpr_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter NREG, default 32: register count, a power of two no smaller than 2; ADDR_W = log2(NREG).
REQ-003 SHALL have parameter NRD, default 2: number of read ports, 1 to 4.
REQ-004 SHALL have the following ports, clock and reset first:
- Clk  in  1  clock; one clock, all state updates on the rising edge.
- Reset  in  1  reset; synchronous and active-high.
- Rreg  in  NRD*ADDR_W  packed read addresses; port i uses slice i.
- Rdata  out  NRD*DATA_W  packed read data; combinational.
- RBusy  out  NRD  per-port flag: register has a pending producer.
- WEa, Wrega, Wdataa  in  1 / ADDR_W / DATA_W  write port A, the high-priority port.
- WEb, Wregb, Wdatab  in  1 / ADDR_W / DATA_W  write port B.
- IssueEn, IssueReg  in  1 / ADDR_W  marks IssueReg as awaiting writeback.
- AnyBusy  out  1  OR of all busy bits.

Function
REQ-005 Register 0 SHALL always read as 0 and SHALL never be written or marked busy.
REQ-006 On a rising edge with WEa=1 and Wrega!=0, register[Wrega] SHALL take the value Wdataa.
- Port B SHALL behave the same way for register[Wregb].
REQ-007 If both ports are enabled for the same nonzero register, port A SHALL win and port B SHALL be dropped for that cycle.
REQ-008 Reads SHALL be combinational, with write-first bypass:
- If a write is enabled this cycle to the addressed nonzero register, Rdata SHALL show that write data, applying the port A priority rule.
- Otherwise Rdata SHALL show the stored value.
REQ-009 Busy bit set/clear:
- A rising edge with IssueEn=1 and IssueReg!=0 SHALL set busy[IssueReg].
- An effective write (not dropped by REQ-007) SHALL clear busy[Wreg].
REQ-010 If a register is issued and written in the same cycle, set SHALL win, because it marks a newer producer.
REQ-011 RBusy[i] SHALL equal busy[Rreg_i] AND NOT (an effective write to Rreg_i this cycle).
- Bypassed data is therefore never reported busy.
REQ-012 Issuing an already-busy register SHALL leave it busy; no error or count is kept.
REQ-013 Writing a non-busy register SHALL update the data and leave busy at 0.
REQ-014 AnyBusy SHALL reflect the registered busy vector only, with no same-cycle bypass.
REQ-015 All writes, issues and busy clears SHALL take effect with exactly one cycle of latency; reads SHALL have zero latency.

Reset
REQ-016 An edge with Reset=1 SHALL clear every register to 0 and every busy bit to 0.
REQ-017 Writes and issues presented in a Reset cycle SHALL be ignored, with no effect on state.
REQ-018 While Reset=1, Rdata SHALL show stored contents with bypass disabled, and RBusy SHALL be 0.
REQ-019 State SHALL be fully defined after one reset edge; no initial blocks SHALL be relied on.

Structure
REQ-020 Shared package gpr_pkg SHALL hold the default DATA_W, NREG and NRD values and the zero-register index constant.
REQ-021 The busy-bit logic (REQ-009 to REQ-014) SHALL be a sub-module, gpr_scoreboard, with parameter NREG.
- Its inputs SHALL be the issue port and the two effective-write strobes with their addresses.
- Its outputs SHALL be the busy vector and AnyBusy.
REQ-022 The data array SHALL be NREG entries of DATA_W bits.
- Entry 0 need not be physically stored.

Verification
REQ-023 Reset, then read all registers → every Rdata is 0, RBusy is 0 and AnyBusy is 0.
REQ-024 Write 0xDEADBEEF to r5 via port A while reading r5 in the same cycle → Rdata shows 0xDEADBEEF in that cycle, and r5 holds it next cycle.
REQ-025 Port A writes 0x11 to r7 while port B writes 0x22 to r7 → r7 = 0x11.
- Also: write 0x33 to r0 → r0 still reads 0.
REQ-026 Issue r9, then hold it two cycles → RBusy=1 and AnyBusy=1.
- Then write 0x55 to r9 via port B → RBusy=0 in that cycle and Rdata=0x55; next cycle AnyBusy=0.
REQ-027 Issue r3 and write r3 (0x77) in the same cycle → next cycle r3=0x77 and busy[r3]=1.
REQ-028 Set r4=0x99 and issue r4, then assert Reset together with a write of 0xAA to r4 → next cycle r4=0 and busy is empty.
